// File: rtl/fwd_hazard_unit.sv
// Operand bypass and interlock unit for the decode stage.
// Resolves each source operand from the youngest matching in-flight result,
// the long-latency writeback port, or the register file, and raises a stall
// on load-use hazards or reads of registers owned by an outstanding
// long-latency operation. A watchdog flags runs of consecutive stalls.
module fwd_hazard_unit #(
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int MAX_STALL = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [NUM_SRC*DATA_W-1:0]   rf_value,
    input  logic [NUM_FWD-1:0]          fwd_valid,
    input  logic [NUM_FWD-1:0]          fwd_ready,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_value,
    input  logic                        lc_issue,
    input  logic [ADDR_W-1:0]           lc_addr,
    input  logic                        lc_done,
    input  logic [ADDR_W-1:0]           lc_done_addr,
    input  logic [DATA_W-1:0]           lc_done_value,
    output logic [NUM_SRC*DATA_W-1:0]   src_value,
    output logic [NUM_SRC-1:0]          src_fwd,
    output logic                        stall,
    output logic [(1<<ADDR_W)-1:0]      pending,
    output logic                        err_deadlock
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(MAX_STALL - 1);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_next;
    logic [NUM_SRC-1:0]  hazard;
    logic [CNT_W-1:0]    stall_cnt;

    assign pending = pending_q;

    // Per-operand source selection: r0, youngest stage, lc port, scoreboard, RF.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a value unassigned and infer a latch.
        src_value = '0;
        src_fwd   = '0;
        hazard    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [ADDR_W-1:0] addr;
            logic              hit;
            addr = id_src_addr[i*ADDR_W +: ADDR_W];
            hit  = 1'b0;
            if (addr != '0) begin
                // Only the youngest matching stage counts; older copies are stale.
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (!hit && fwd_valid[k] && (fwd_addr[k*ADDR_W +: ADDR_W] == addr)) begin
                        hit = 1'b1;
                        if (fwd_ready[k]) begin
                            src_value[i*DATA_W +: DATA_W] = fwd_value[k*DATA_W +: DATA_W];
                            src_fwd[i]                    = 1'b1;
                        end else begin
                            hazard[i] = 1'b1;
                        end
                    end
                end
                if (!hit) begin
                    if (lc_done && (lc_done_addr == addr)) begin
                        src_value[i*DATA_W +: DATA_W] = lc_done_value;
                        src_fwd[i]                    = 1'b1;
                    end else if (pending_q[addr]) begin
                        hazard[i] = 1'b1;
                    end else begin
                        src_value[i*DATA_W +: DATA_W] = rf_value[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Unused operands still resolve a value but never hold the pipeline.
    assign stall = id_valid && |(id_src_used & hazard);

    // Scoreboard update: clear on writeback, then set on issue so set wins.
    always_comb begin
        pending_next = pending_q;
        if (lc_done) begin
            pending_next[lc_done_addr] = 1'b0;
        end
        if (lc_issue && (lc_addr != '0)) begin
            pending_next[lc_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset in
        // full; a stale pending bit after reset would stall forever.
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values.
            pending_q <= pending_next;
        end
    end

    // Consecutive-stall watchdog with sticky deadlock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt    <= '0;
            err_deadlock <= 1'b0;
        end else begin
            if (!stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall && (stall_cnt >= CNT_TRIP)) begin
                err_deadlock <= 1'b1;
            end
        end
    end

endmodule
